branch_redirect_ctrl: RTL and testbench

//  Sequences the PC redirect after a branch resolves in MEM. Decides taken/not-taken and picks the target.

---
 rtl/branch_pkg.sv | 6 +
 rtl/branch_resolve.sv | 29 ++
 rtl/branch_redirect_ctrl.sv | 97 +++++++++
 tb/tb_branch_redirect_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types for the branch redirect path: branch kinds, redirect FSM states, flush width.
package branch_pkg;
  typedef enum logic [1:0] {BK_NONE, BK_CBZ, BK_BR, BK_B} br_kind_t;
  typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_SHADOW} redir_state_t;
  localparam int FLUSH_W = 3;
endpackage

// File: rtl/branch_resolve.sv
// Combinational branch decision: taken flag and target select from kind, zero flag and targets.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int PC_W = 64
) (
  input  br_kind_t          br_kind,
  input  logic              br_zero,
  input  logic [PC_W-1:0]   imm_target,
  input  logic [PC_W-1:0]   abs_target,
  output logic              taken,
  output logic [PC_W-1:0]   target
);

  always_comb begin
    taken  = 1'b0;
    target = imm_target;
    case (br_kind)
      BK_CBZ:  taken = br_zero;
      BK_BR: begin
        taken  = 1'b1;
        target = abs_target;
      end
      BK_B:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// PC redirect sequencer: IDLE -> REDIRECT (valid/ready to fetch, flush) -> SHADOW (drop wrong-path branches).
// Optional statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_redirect_ctrl
  import branch_pkg::*;
#(
  parameter int PC_W     = 64,
  parameter int SHADOW_N = 3,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               br_valid,
  input  logic [1:0]         br_kind,
  input  logic               br_zero,
  input  logic [PC_W-1:0]    imm_target,
  input  logic [PC_W-1:0]    abs_target,
  output logic               redir_valid,
  input  logic               redir_ready,
  output logic [PC_W-1:0]    redir_pc,
  output logic [FLUSH_W-1:0] flush,
  output logic               stall_mem,
  output logic               squashed
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0]   taken_cnt,
  output logic [CNT_W-1:0]   ntaken_cnt
`endif
);

  localparam int SH_W = $clog2(SHADOW_N + 1);
  localparam logic [SH_W-1:0] SHADOW_LAST = SH_W'(SHADOW_N - 1);

  redir_state_t    state;
  logic [SH_W-1:0] cnt;
  logic            taken;
  logic [PC_W-1:0] target;
  logic            live_br;

  branch_resolve #(.PC_W(PC_W)) u_resolve (
    .br_kind    (br_kind_t'(br_kind)),
    .br_zero    (br_zero),
    .imm_target (imm_target),
    .abs_target (abs_target),
    .taken      (taken),
    .target     (target)
  );

  assign live_br     = br_valid && (br_kind != BK_NONE);
  assign redir_valid = (state == S_REDIRECT);
  assign flush       = {FLUSH_W{redir_valid}};
  assign stall_mem   = redir_valid;
  assign squashed    = (state == S_SHADOW) && live_br;

  // cnt counts down from SHADOW_N-1 so that SHADOW spans exactly SHADOW_N cycles
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      redir_pc <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (br_valid && taken) begin
            state    <= S_REDIRECT;
            redir_pc <= target;
          end
        end
        S_REDIRECT: begin
          if (redir_ready) begin
            state <= S_SHADOW;
            cnt   <= SHADOW_LAST;
          end
        end
        S_SHADOW: begin
          if (cnt == '0) state <= S_IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  // only branches resolved in IDLE are counted; shadow-squashed ones never are
  always_ff @(posedge clk) begin
    if (!reset) begin
      taken_cnt  <= '0;
      ntaken_cnt <= '0;
    end else if (state == S_IDLE && br_valid) begin
      if (taken)                       taken_cnt  <= taken_cnt + 1'b1;
      else if (br_kind != BK_NONE)     ntaken_cnt <= ntaken_cnt + 1'b1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl with a cycle-level reference model and per-cycle compare.
module tb_branch_redirect_ctrl;
  localparam int PC_W = 64;
  localparam int SH   = 3;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            br_valid;
  logic [1:0]      br_kind;
  logic            br_zero;
  logic [PC_W-1:0] imm_target;
  logic [PC_W-1:0] abs_target;
  logic            redir_valid;
  logic            redir_ready;
  logic [PC_W-1:0] redir_pc;
  logic [2:0]      flush;
  logic            stall_mem;
  logic            squashed;
`ifdef BRANCH_STATS_EN
  logic [CW-1:0]   taken_cnt;
  logic [CW-1:0]   ntaken_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  branch_redirect_ctrl #(.PC_W(PC_W), .SHADOW_N(SH), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .br_valid    (br_valid),
    .br_kind     (br_kind),
    .br_zero     (br_zero),
    .imm_target  (imm_target),
    .abs_target  (abs_target),
    .redir_valid (redir_valid),
    .redir_ready (redir_ready),
    .redir_pc    (redir_pc),
    .flush       (flush),
    .stall_mem   (stall_mem),
    .squashed    (squashed)
`ifdef BRANCH_STATS_EN
    ,
    .taken_cnt   (taken_cnt),
    .ntaken_cnt  (ntaken_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an outstanding redirect, a target, and shadow cycles left.
  bit              m_pend = 1'b0;
  logic [PC_W-1:0] m_pc = '0;
  int              m_shadow = 0;
  logic [CW-1:0]   m_taken = '0;
  logic [CW-1:0]   m_ntaken = '0;

  always @(posedge clk) begin
    bit tk;
    if (!reset) begin
      m_pend = 1'b0; m_pc = '0; m_shadow = 0; m_taken = '0; m_ntaken = '0;
    end else if (m_pend) begin
      if (redir_ready) begin
        m_pend   = 1'b0;
        m_shadow = SH;
      end
    end else if (m_shadow > 0) begin
      m_shadow = m_shadow - 1;
    end else if (br_valid) begin
      tk = (br_kind == 2'd2) || (br_kind == 2'd3) || (br_kind == 2'd1 && br_zero);
      if (tk) begin
        m_pend  = 1'b1;
        m_pc    = (br_kind == 2'd2) ? abs_target : imm_target;
        m_taken = m_taken + 1'b1;
      end else if (br_kind != 2'd0) begin
        m_ntaken = m_ntaken + 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("redir_valid", 64'(redir_valid), 64'(m_pend));
      chk("redir_pc", redir_pc, m_pc);
      chk("flush", 64'(flush), m_pend ? 64'd7 : 64'd0);
      chk("stall_mem", 64'(stall_mem), 64'(m_pend));
      chk("squashed", 64'(squashed), 64'((m_shadow > 0) && br_valid && (br_kind != 2'd0)));
`ifdef BRANCH_STATS_EN
      chk("taken_cnt", 64'(taken_cnt), 64'(m_taken));
      chk("ntaken_cnt", 64'(ntaken_cnt), 64'(m_ntaken));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic bv, input logic [1:0] kind, input logic zero,
                       input logic [63:0] imm, input logic [63:0] abs_t, input logic rdy);
    br_valid = bv; br_kind = kind; br_zero = zero;
    imm_target = imm; abs_target = abs_t; redir_ready = rdy;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 2'd0, 0, 0, 0, 0);
    step(); step();
    reset = 1'b1;
    mon_en = 1'b1;
    chk("rst_valid", 64'(redir_valid), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_pc", redir_pc, 64'd0);

    // CBZ taken, accepted on the next cycle
    drive(1, 2'd1, 1, 64'h40, 64'h999, 0);
    step();
    chk("t1_valid", 64'(redir_valid), 64'd1);
    chk("t1_pc", redir_pc, 64'h40);
    chk("t1_flush", 64'(flush), 64'd7);
    drive(0, 2'd0, 0, 0, 0, 1);
    step();
    chk("t1_shadow_valid", 64'(redir_valid), 64'd0);
    chk("t1_shadow_flush", 64'(flush), 64'd0);
    step(); step(); step();

    // CBZ not taken
    drive(1, 2'd1, 0, 64'h50, 64'h0, 0);
    step();
    chk("t2_valid", 64'(redir_valid), 64'd0);
    chk("t2_flush", 64'(flush), 64'd0);
`ifdef BRANCH_STATS_EN
    chk("t2_ntaken", 64'(ntaken_cnt), 64'd1);
`endif
    drive(0, 2'd0, 0, 0, 0, 1);
    step();
    chk("ready_idle", 64'(redir_valid), 64'd0);

    // BR with fetch back-pressure for 4 cycles
    drive(1, 2'd2, 0, 64'h99, 64'h1234, 0);
    step();
    drive(0, 2'd0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t3_hold_pc", redir_pc, 64'h1234);
      chk("t3_hold_stall", 64'(stall_mem), 64'd1);
      step();
    end
    chk("t3_cycle5_valid", 64'(redir_valid), 64'd1);
    redir_ready = 1'b1;
    step();
    chk("t3_done", 64'(redir_valid), 64'd0);
    redir_ready = 1'b0;
    step(); step(); step();

    // B taken, then wrong-path branches through the whole shadow
    drive(1, 2'd3, 0, 64'h80, 64'h0, 0);
    step();
    chk("t4_pc", redir_pc, 64'h80);
    drive(0, 2'd0, 0, 0, 0, 1);
    step();
    drive(1, 2'd3, 0, 64'h200, 64'h0, 0);
    for (int i = 0; i < SH; i++) begin
      #1;
      chk("t4_squash", 64'(squashed), 64'd1);
      chk("t4_no_redir", 64'(redir_valid), 64'd0);
      step();
    end
    #1;
    chk("t4_idle_squash", 64'(squashed), 64'd0);
    step();
    chk("t4_redir", 64'(redir_valid), 64'd1);
    chk("t4_redir_pc", redir_pc, 64'h200);

    // reset while a redirect is pending
    drive(0, 2'd0, 0, 0, 0, 0);
    reset = 1'b0;
    step();
    chk("t5_valid", 64'(redir_valid), 64'd0);
    chk("t5_pc", redir_pc, 64'd0);
    chk("t5_stall", 64'(stall_mem), 64'd0);
`ifdef BRANCH_STATS_EN
    chk("t5_taken", 64'(taken_cnt), 64'd0);
    chk("t5_ntaken", 64'(ntaken_cnt), 64'd0);
`endif
    reset = 1'b1;

    // 16 taken branches: statistics counter wraps 15 -> 0
    for (int i = 0; i < 16; i++) begin
      drive(1, 2'd3, 0, 64'(i * 16 + 8), 64'h0, 0);
      step();
      chk("t6_pc", redir_pc, 64'(i * 16 + 8));
`ifdef BRANCH_STATS_EN
      chk("t6_taken", 64'(taken_cnt), 64'((i + 1) % 16));
`endif
      drive(0, 2'd0, 0, 0, 0, 1);
      step(); step(); step(); step();
    end

    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
